// File: rtl/alu_flag_unit_if.sv
// Capture/result bus between the ALU-side environment and alu_flag_unit.
// The master modport is the environment side and the slave modport is the flag unit.
interface alu_flag_unit_if #(
  parameter int WIDTH = 8
);
  logic             cap_valid;
  logic             cap_ready;
  logic [2:0]       func;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             zero;
  logic             negetive;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_flags;

  modport master (
    output cap_valid, func, result, carryOut, zero, negetive, out_ready,
    input  cap_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  cap_valid, func, result, carryOut, zero, negetive, out_ready,
    output cap_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/alu_flag_unit.sv
// ALU flag register (C/Z/N) with a carry feedback path and a result/flag FIFO.
// Optional flag consistency checker: define ALU_FLAG_CHECK_EN to add the flag_err port.
module alu_flag_unit #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_flag_unit_if.slave bus,
  input  logic          clr_c,
  output logic          carryIn,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n,
  output logic [CW-1:0] count,
  output logic          drop_err
`ifdef ALU_FLAG_CHECK_EN
  ,
  output logic          flag_err
`endif
);

  typedef struct packed {
    logic             c;
    logic             z;
    logic             n;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          carry_func;
  logic          func_unused;

  assign bus.cap_ready = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.cap_valid & bus.cap_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Only add/sub codes (000, 001) update the architectural carry.
  assign carry_func    = (bus.func[2:1] == 2'b00);
  assign func_unused   = bus.func[0];

  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_flags = {mem[rd_ptr].c, mem[rd_ptr].z, mem[rd_ptr].n};
  assign carryIn       = flag_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{c: bus.carryOut, z: bus.zero, n: bus.negetive, data: bus.result};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (clr_c) begin
        flag_c <= 1'b0;
      end else if (push && carry_func) begin
        flag_c <= bus.carryOut;
      end
      if (push) begin
        flag_z <= bus.zero;
        flag_n <= bus.negetive;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err <= 1'b0;
    end else if (bus.cap_valid && !bus.cap_ready) begin
      drop_err <= 1'b1;
    end
  end

`ifdef ALU_FLAG_CHECK_EN
  logic z_calc;
  logic n_calc;

  assign z_calc = (bus.result == '0);
  assign n_calc = bus.result[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_err <= 1'b0;
    end else if (push && ((z_calc != bus.zero) || (n_calc != bus.negetive))) begin
      flag_err <= 1'b1;
    end
  end
`endif

endmodule
